// File: rtl/uart_apb_regif_pkg.sv
// Shared definitions for the UART APB register front-end: register offsets,
// FSM encoding, STATUS bit positions and configuration widths.
package uart_apb_regif_pkg;

    localparam int BAUD_W = 13;
    localparam int FRAC_W = 3;

    localparam logic [2:0] REG_TXDATA = 3'd0;
    localparam logic [2:0] REG_RXDATA = 3'd1;
    localparam logic [2:0] REG_CTRL1  = 3'd2;
    localparam logic [2:0] REG_CTRL2  = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;
    localparam logic [2:0] REG_CTRL3  = 3'd5;

    localparam int ST_TXRDY       = 0;
    localparam int ST_RXRDY       = 1;
    localparam int ST_PARITY_ERR  = 2;
    localparam int ST_OVERFLOW    = 3;
    localparam int ST_FRAMING_ERR = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RDWAIT = 2'd2
    } state_t;

    // Offsets 6 and 7 are the only holes in the 3-bit register index space.
    function automatic logic reg_mapped(input logic [2:0] idx);
        return idx <= REG_CTRL3;
    endfunction

endpackage

// File: rtl/uart_apb_regif_if.sv
// APB3 bus bundle between a master and the UART register front-end.
interface uart_apb_regif_if;

    // Handshake: a transfer is set up when psel=1 and penable=0; the master then
    // raises penable and holds all request fields until it samples pready=1 on a
    // rising clock edge, which completes the transfer (prdata/pslverr valid then).
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [4:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/uart_apb_regif.sv
// APB3 slave front-end for the UART core: drives the core's active-low strobes,
// holds the baud/frame configuration and returns RX data and status to the bus.
module uart_apb_regif
    import uart_apb_regif_pkg::*;
#(
    parameter bit                FIXEDMODE    = 1'b0,
    parameter logic [BAUD_W-1:0] BAUD_VALUE_P = 13'd1,
    parameter logic [FRAC_W-1:0] BAUD_FRAC_P  = 3'd0,
    parameter logic [2:0]        CFG_P        = 3'b001
) (
    input  logic              pclk,
    input  logic              presetn,
    uart_apb_regif_if.slave   apb,
    output logic              csn,
    output logic              wen,
    output logic              oen,
    output logic [7:0]        data_in,
    output logic [BAUD_W-1:0] baud_val,
    output logic [FRAC_W-1:0] baud_val_fraction,
    output logic              bit8,
    output logic              parity_en,
    output logic              odd_n_even,
    input  logic [7:0]        data_out,
    input  logic              txrdy,
    input  logic              rxrdy,
    input  logic              parity_err,
    input  logic              overflow,
    input  logic              framing_err,
    output state_t            dbg_state
);

    state_t            state, state_nxt;
    logic [2:0]        idx_q;
    logic              write_q;
    logic [7:0]        wdata_q;
    logic [7:0]        prdata_q;
    logic [BAUD_W-1:0] baud_q;
    logic [FRAC_W-1:0] frac_q;
    logic [2:0]        cfg_q;
    logic              csn_nxt, wen_nxt, oen_nxt;
    logic              setup, is_tx_wr, is_rx_rd, rx_rd_q, cfg_wr;
    logic [7:0]        status, rd_mux;
    logic              addr_lsb_unused;

    assign addr_lsb_unused = ^apb.paddr[1:0];

    assign setup    = apb.psel & ~apb.penable;
    assign is_tx_wr = apb.pwrite  && (apb.paddr[4:2] == REG_TXDATA);
    assign is_rx_rd = !apb.pwrite && (apb.paddr[4:2] == REG_RXDATA);
    assign rx_rd_q  = !write_q && (idx_q == REG_RXDATA);
    assign cfg_wr   = (state == S_ACCESS) && write_q && !FIXEDMODE;

    always_comb begin
        status                 = '0;
        status[ST_TXRDY]       = txrdy;
        status[ST_RXRDY]       = rxrdy;
        status[ST_PARITY_ERR]  = parity_err;
        status[ST_OVERFLOW]    = overflow;
        status[ST_FRAMING_ERR] = framing_err;
    end

    always_comb begin
        rd_mux = '0;
        case (idx_q)
            REG_CTRL1:  rd_mux = baud_q[7:0];
            REG_CTRL2:  rd_mux = {baud_q[BAUD_W-1:8], cfg_q};
            REG_STATUS: rd_mux = status;
            REG_CTRL3:  rd_mux = {5'b0, frac_q};
            default:    rd_mux = '0;
        endcase
    end

    // Strobes are registered from the setup decode so they are low for exactly
    // the ACCESS cycle and return high on every other path.
    always_comb begin
        state_nxt   = state;
        csn_nxt     = 1'b1;
        wen_nxt     = 1'b1;
        oen_nxt     = 1'b1;
        apb.pready  = 1'b0;
        apb.pslverr = 1'b0;
        apb.prdata  = '0;
        case (state)
            S_IDLE: begin
                if (setup) begin
                    state_nxt = S_ACCESS;
                    csn_nxt   = !(is_tx_wr || is_rx_rd);
                    wen_nxt   = !is_tx_wr;
                    oen_nxt   = !is_rx_rd;
                end
            end
            S_ACCESS: begin
                if (rx_rd_q) begin
                    state_nxt = S_RDWAIT;
                end else begin
                    state_nxt   = S_IDLE;
                    apb.pready  = 1'b1;
                    apb.pslverr = !reg_mapped(idx_q);
                    if (!write_q) apb.prdata = rd_mux;
                end
            end
            S_RDWAIT: begin
                state_nxt  = S_IDLE;
                apb.pready = 1'b1;
                apb.prdata = prdata_q;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            csn      <= 1'b1;
            wen      <= 1'b1;
            oen      <= 1'b1;
            data_in  <= '0;
            idx_q    <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            prdata_q <= '0;
        end else begin
            csn <= csn_nxt;
            wen <= wen_nxt;
            oen <= oen_nxt;
            if (state == S_IDLE && setup) begin
                idx_q   <= apb.paddr[4:2];
                write_q <= apb.pwrite;
                wdata_q <= apb.pwdata;
                if (is_tx_wr) data_in <= apb.pwdata;
            end
            if (state == S_ACCESS && rx_rd_q) prdata_q <= data_out;
        end
    end

    // With FIXEDMODE set the write enable is constant 0, so these hold the *_P values.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            baud_q <= BAUD_VALUE_P;
            frac_q <= BAUD_FRAC_P;
            cfg_q  <= CFG_P;
        end else if (cfg_wr) begin
            case (idx_q)
                REG_CTRL1: baud_q[7:0] <= wdata_q;
                REG_CTRL2: begin
                    baud_q[BAUD_W-1:8] <= wdata_q[7:3];
                    cfg_q              <= wdata_q[2:0];
                end
                REG_CTRL3: frac_q <= wdata_q[FRAC_W-1:0];
                default: ;
            endcase
        end
    end

    assign baud_val          = baud_q;
    assign baud_val_fraction = frac_q;
    assign bit8              = cfg_q[0];
    assign parity_en         = cfg_q[1];
    assign odd_n_even        = cfg_q[2];
    assign dbg_state         = state;

endmodule
